mod_mem_arbiter: RTL and testbench
==================================

Name: mod_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single direct-mapped write-through cache port.
- Port 0 is instruction fetch (read-only, abortable on branch flush). Port 1 is load/store (read or write).
- Grants one transaction at a time, issues a one-cycle read/write pulse to the cache, routes the cache strobe and readdata back to the owner, and drives cache abort on fetch flush.
- Priority: load/store first, with a starvation limit that forces a fetch grant.

Parameters:
- XLEN, 32, data/address width
- BE_WIDTH, 4, byte-enable width
- STARVE_LIMIT, 4, consecutive load/store grants allowed while fetch waits (range 1..15)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held high with stable address until if_stb_o or flush
- if_address_i  in  XLEN  fetch address
- if_abort_i  in  1  fetch flush; cancels the pending or in-flight fetch
- if_readdata_o  out  XLEN  fetch data, valid while if_stb_o is high
- if_stb_o  out  1  one-cycle fetch completion pulse
- ls_req_i  in  1  load/store request; held high with stable fields until ls_stb_o
- ls_write_i  in  1  1 = write, 0 = read
- ls_address_i  in  XLEN  load/store address
- ls_writedata_i  in  XLEN  store data
- ls_byteenable_i  in  BE_WIDTH  byte enables
- ls_readdata_o  out  XLEN  load data, valid while ls_stb_o is high
- ls_stb_o  out  1  one-cycle load/store completion pulse
- mem_address_o  out  XLEN  to cache address_i
- mem_writedata_o  out  XLEN  to cache writedata_i
- mem_byteenable_o  out  BE_WIDTH  to cache byteenable_i
- mem_read_o  out  1  to cache read_i, one-cycle pulse
- mem_write_o  out  1  to cache write_i, one-cycle pulse
- mem_abort_o  out  1  to cache abort_i, one-cycle pulse
- mem_readdata_i  in  XLEN  from cache readdata_o
- mem_stb_i  in  1  from cache stb_o
- mem_busy_i  in  1  from cache busy_o
- owner_o  out  1  0 = fetch, 1 = load/store; current or last grant

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, owner_o = 0, starve counter = 0. All mem_* outputs and all stb/readdata outputs are 0. Reset mid-transaction drops the transaction silently; no stb is produced.
- All outputs are registered.

States and transitions:
- IDLE -> ISSUE: when mem_busy_i = 0 and at least one request qualifies. A fetch request qualifies only if if_abort_i = 0 in the same cycle.
  - Winner selection: fetch wins if only fetch requests, or if both request and starve count = STARVE_LIMIT. Otherwise load/store wins.
  - On the transition, latch the winner's address, writedata, byteenable and direction into mem_*; set owner_o.
- ISSUE (1 cycle): mem_read_o or mem_write_o = 1 (fetch always reads). Next state is WAIT. If if_abort_i is high and owner = fetch, the read pulse is still issued and the next state is DRAIN with mem_abort_o pulsed.
- WAIT: on mem_stb_i:
  - Copy mem_readdata_i to the owner's readdata_o and pulse the owner's stb_o the next cycle (latency 1 after mem_stb_i).
  - Clear mem_* fields; return to IDLE.
  - A cache hit gives a minimum total latency of 4 cycles from request to stb.
- WAIT with owner = fetch and if_abort_i = 1 and mem_stb_i = 0: pulse mem_abort_o for one cycle, go to DRAIN.
- WAIT with if_abort_i and mem_stb_i in the same cycle: the strobe wins. Data is discarded, no if_stb_o, no mem_abort_o, go to IDLE.
- if_abort_i while load/store owns the port: ignored.
- DRAIN: wait for mem_stb_i, or for mem_busy_i = 0 for 2 consecutive cycles, then go to IDLE. Never pulse if_stb_o.

Starve counter (4-bit, saturating at STARVE_LIMIT):
- Increments on each load/store grant while if_req_i is high.
- Clears on a fetch grant, or on a load/store grant while if_req_i is low.

Other rules:
- At most one stb output is high in any cycle.
- The readdata output of the non-owner holds its previous value.
- Requests arriving while not in IDLE wait; there is no queueing beyond the held request lines.

Test Plan:
- Fetch only, addr 0x0000_0040; cache returns stb 2 cycles after the read pulse with data 0x0000_0013 -> one mem_read_o pulse with mem_address_o = 0x40; if_stb_o = 1 with if_readdata_o = 0x13 one cycle after mem_stb_i; ls_stb_o stays 0.
- Both requesting every cycle, STARVE_LIMIT = 4 -> grant sequence LS, LS, LS, LS, IF, LS...; owner_o matches; counter clears after the IF grant.
- Store addr 0x100, data 0xDEADBEEF, BE 4'b1111 -> one mem_write_o pulse with the matching fields; ls_stb_o after mem_stb_i; if_stb_o = 0.
- Fetch in flight, if_abort_i pulsed in WAIT -> mem_abort_o pulses once; the cache's later stb is swallowed (no if_stb_o); the next ls_req_i is granted normally.
- if_abort_i coincident with mem_stb_i -> no if_stb_o, no mem_abort_o, state returns to IDLE.
- rst_ni pulled low during WAIT -> all outputs 0 immediately (asynchronous), IDLE after release, no stb.

Source files
------------

// File: rtl/mod_mem_arbiter.sv
// Two-requester arbiter and sequencer in front of a single cache port.
// Load/store has priority; a saturating starvation counter forces a fetch grant.
module mod_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int BE_WIDTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // Instruction fetch port
  input  logic                if_req_i,
  input  logic [XLEN-1:0]     if_address_i,
  input  logic                if_abort_i,
  output logic [XLEN-1:0]     if_readdata_o,
  output logic                if_stb_o,
  // Load/store port
  input  logic                ls_req_i,
  input  logic                ls_write_i,
  input  logic [XLEN-1:0]     ls_address_i,
  input  logic [XLEN-1:0]     ls_writedata_i,
  input  logic [BE_WIDTH-1:0] ls_byteenable_i,
  output logic [XLEN-1:0]     ls_readdata_o,
  output logic                ls_stb_o,
  // Cache port
  output logic [XLEN-1:0]     mem_address_o,
  output logic [XLEN-1:0]     mem_writedata_o,
  output logic [BE_WIDTH-1:0] mem_byteenable_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_abort_o,
  input  logic [XLEN-1:0]     mem_readdata_i,
  input  logic                mem_stb_i,
  input  logic                mem_busy_i,
  output logic                owner_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);

  state_t              r_state,          w_state_nxt;
  logic [3:0]          r_starve,         w_starve_nxt;
  logic                r_drain_idle,     w_drain_idle_nxt;
  logic                r_owner,          w_owner_nxt;
  logic [XLEN-1:0]     r_mem_address,    w_mem_address_nxt;
  logic [XLEN-1:0]     r_mem_writedata,  w_mem_writedata_nxt;
  logic [BE_WIDTH-1:0] r_mem_byteenable, w_mem_byteenable_nxt;
  logic                r_mem_read,       w_mem_read_nxt;
  logic                r_mem_write,      w_mem_write_nxt;
  logic                r_mem_abort,      w_mem_abort_nxt;
  logic [XLEN-1:0]     r_if_readdata,    w_if_readdata_nxt;
  logic [XLEN-1:0]     r_ls_readdata,    w_ls_readdata_nxt;
  logic                r_if_stb,         w_if_stb_nxt;
  logic                r_ls_stb,         w_ls_stb_nxt;

  logic w_if_qual;
  logic w_grant_ok;
  logic w_pick_if;

  // A flushed fetch does not compete. No grant during a completion-strobe
  // cycle: the finishing requester still holds its line high for that cycle.
  assign w_if_qual  = if_req_i & ~if_abort_i;
  assign w_grant_ok = ~mem_busy_i & ~r_if_stb & ~r_ls_stb;
  assign w_pick_if  = w_if_qual & (~ls_req_i | (r_starve == LP_STARVE_MAX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    w_state_nxt          = r_state;
    w_starve_nxt         = r_starve;
    w_drain_idle_nxt     = r_drain_idle;
    w_owner_nxt          = r_owner;
    w_mem_address_nxt    = r_mem_address;
    w_mem_writedata_nxt  = r_mem_writedata;
    w_mem_byteenable_nxt = r_mem_byteenable;
    w_mem_read_nxt       = 1'b0;
    w_mem_write_nxt      = 1'b0;
    w_mem_abort_nxt      = 1'b0;
    w_if_readdata_nxt    = r_if_readdata;
    w_ls_readdata_nxt    = r_ls_readdata;
    w_if_stb_nxt         = 1'b0;
    w_ls_stb_nxt         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_grant_ok && (w_if_qual || ls_req_i)) begin
          w_state_nxt = S_ISSUE;
          if (w_pick_if) begin
            w_owner_nxt          = 1'b0;
            w_mem_address_nxt    = if_address_i;
            w_mem_writedata_nxt  = '0;
            w_mem_byteenable_nxt = '1;
            w_mem_read_nxt       = 1'b1;
            w_starve_nxt         = 4'd0;
          end else begin
            w_owner_nxt          = 1'b1;
            w_mem_address_nxt    = ls_address_i;
            w_mem_writedata_nxt  = ls_writedata_i;
            w_mem_byteenable_nxt = ls_byteenable_i;
            w_mem_read_nxt       = ~ls_write_i;
            w_mem_write_nxt      = ls_write_i;
            if (!if_req_i)                      w_starve_nxt = 4'd0;
            else if (r_starve != LP_STARVE_MAX) w_starve_nxt = r_starve + 4'd1;
          end
        end
      end

      S_ISSUE: begin
        if (!r_owner && if_abort_i) begin
          w_state_nxt      = S_DRAIN;
          w_mem_abort_nxt  = 1'b1;
          w_drain_idle_nxt = 1'b0;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_stb_i) begin
          w_state_nxt          = S_IDLE;
          w_mem_address_nxt    = '0;
          w_mem_writedata_nxt  = '0;
          w_mem_byteenable_nxt = '0;
          if (r_owner) begin
            w_ls_readdata_nxt = mem_readdata_i;
            w_ls_stb_nxt      = 1'b1;
          end else if (!if_abort_i) begin
            w_if_readdata_nxt = mem_readdata_i;
            w_if_stb_nxt      = 1'b1;
          end
        end else if (!r_owner && if_abort_i) begin
          w_state_nxt      = S_DRAIN;
          w_mem_abort_nxt  = 1'b1;
          w_drain_idle_nxt = 1'b0;
        end
      end

      S_DRAIN: begin
        // Leave on the orphaned strobe or after two consecutive idle cycles.
        if (mem_stb_i || (!mem_busy_i && r_drain_idle)) begin
          w_state_nxt          = S_IDLE;
          w_drain_idle_nxt     = 1'b0;
          w_mem_address_nxt    = '0;
          w_mem_writedata_nxt  = '0;
          w_mem_byteenable_nxt = '0;
        end else begin
          w_drain_idle_nxt = ~mem_busy_i;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve         <= 4'd0;
      r_drain_idle     <= 1'b0;
      r_owner          <= 1'b0;
      r_mem_address    <= '0;
      r_mem_writedata  <= '0;
      r_mem_byteenable <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_abort      <= 1'b0;
      r_if_readdata    <= '0;
      r_ls_readdata    <= '0;
      r_if_stb         <= 1'b0;
      r_ls_stb         <= 1'b0;
    end else begin
      r_starve         <= w_starve_nxt;
      r_drain_idle     <= w_drain_idle_nxt;
      r_owner          <= w_owner_nxt;
      r_mem_address    <= w_mem_address_nxt;
      r_mem_writedata  <= w_mem_writedata_nxt;
      r_mem_byteenable <= w_mem_byteenable_nxt;
      r_mem_read       <= w_mem_read_nxt;
      r_mem_write      <= w_mem_write_nxt;
      r_mem_abort      <= w_mem_abort_nxt;
      r_if_readdata    <= w_if_readdata_nxt;
      r_ls_readdata    <= w_ls_readdata_nxt;
      r_if_stb         <= w_if_stb_nxt;
      r_ls_stb         <= w_ls_stb_nxt;
    end
  end

  assign if_readdata_o    = r_if_readdata;
  assign if_stb_o         = r_if_stb;
  assign ls_readdata_o    = r_ls_readdata;
  assign ls_stb_o         = r_ls_stb;
  assign mem_address_o    = r_mem_address;
  assign mem_writedata_o  = r_mem_writedata;
  assign mem_byteenable_o = r_mem_byteenable;
  assign mem_read_o       = r_mem_read;
  assign mem_write_o      = r_mem_write;
  assign mem_abort_o      = r_mem_abort;
  assign owner_o          = r_owner;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Directed bench for mod_mem_arbiter: a vector table of single transactions
// plus hand-written starvation, flush, coincident-flush and reset sequences.
module tb_mod_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int BEW   = 4;
  localparam int LIMIT = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b1;
  logic            if_req_i = 1'b0;
  logic [XLEN-1:0] if_address_i = '0;
  logic            if_abort_i = 1'b0;
  logic [XLEN-1:0] if_readdata_o;
  logic            if_stb_o;
  logic            ls_req_i = 1'b0;
  logic            ls_write_i = 1'b0;
  logic [XLEN-1:0] ls_address_i = '0;
  logic [XLEN-1:0] ls_writedata_i = '0;
  logic [BEW-1:0]  ls_byteenable_i = '0;
  logic [XLEN-1:0] ls_readdata_o;
  logic            ls_stb_o;
  logic [XLEN-1:0] mem_address_o;
  logic [XLEN-1:0] mem_writedata_o;
  logic [BEW-1:0]  mem_byteenable_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_abort_o;
  logic [XLEN-1:0] mem_readdata_i;
  logic            mem_stb_i;
  logic            mem_busy_i;
  logic            owner_o;

  always #5 clk_i = ~clk_i;

  mod_mem_arbiter #(
    .XLEN         (XLEN),
    .BE_WIDTH     (BEW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .if_req_i         (if_req_i),
    .if_address_i     (if_address_i),
    .if_abort_i       (if_abort_i),
    .if_readdata_o    (if_readdata_o),
    .if_stb_o         (if_stb_o),
    .ls_req_i         (ls_req_i),
    .ls_write_i       (ls_write_i),
    .ls_address_i     (ls_address_i),
    .ls_writedata_i   (ls_writedata_i),
    .ls_byteenable_i  (ls_byteenable_i),
    .ls_readdata_o    (ls_readdata_o),
    .ls_stb_o         (ls_stb_o),
    .mem_address_o    (mem_address_o),
    .mem_writedata_o  (mem_writedata_o),
    .mem_byteenable_o (mem_byteenable_o),
    .mem_read_o       (mem_read_o),
    .mem_write_o      (mem_write_o),
    .mem_abort_o      (mem_abort_o),
    .mem_readdata_i   (mem_readdata_i),
    .mem_stb_i        (mem_stb_i),
    .mem_busy_i       (mem_busy_i),
    .owner_o          (owner_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Cache model: strobe cache_delay cycles after a read/write pulse, busy
  // in between. It ignores abort, so an aborted access still strobes.
  int          cache_delay = 2;
  logic [31:0] cache_rdata = '0;

  initial begin : cache_model
    int          cnt;
    logic [31:0] held;
    cnt = 0;
    held = '0;
    mem_stb_i = 1'b0;
    mem_busy_i = 1'b0;
    mem_readdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_stb_i = 1'b0;
      if (!rst_ni) begin
        cnt = 0;
        mem_busy_i = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_stb_i = 1'b1;
          mem_readdata_i = held;
        end
      end else begin
        mem_busy_i = 1'b0;
        if (mem_read_o || mem_write_o) begin
          cnt = cache_delay;
          held = cache_rdata;
          mem_busy_i = 1'b1;
        end
      end
    end
  end

  int n_rd = 0, n_wr = 0, n_abort = 0, n_if_stb = 0, n_ls_stb = 0, n_overlap = 0;

  always @(posedge clk_i) begin
    if (mem_read_o)            n_rd      <= n_rd + 1;
    if (mem_write_o)           n_wr      <= n_wr + 1;
    if (mem_abort_o)           n_abort   <= n_abort + 1;
    if (if_stb_o)              n_if_stb  <= n_if_stb + 1;
    if (ls_stb_o)              n_ls_stb  <= n_ls_stb + 1;
    if (if_stb_o && ls_stb_o)  n_overlap <= n_overlap + 1;
  end

  task automatic wait_issue(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!(mem_read_o || mem_write_o) && cyc < 40);
    check("issue_seen", 32'(mem_read_o | mem_write_o), 32'd1);
  endtask

  task automatic wait_stb(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!(if_stb_o || ls_stb_o) && cyc < 40);
    check("stb_seen", 32'(if_stb_o | ls_stb_o), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_write;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    int          delay;
    logic [31:0] rdata;
    logic        exp_owner;
    logic        exp_write;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_ls_rd = '0;

  task automatic run_vec(input vec_t v);
    int cyc_a;
    int cyc_b;
    cache_delay     = v.delay;
    cache_rdata     = v.rdata;
    if_req_i        = v.if_req;
    if_address_i    = v.if_addr;
    ls_req_i        = v.ls_req;
    ls_write_i      = v.ls_write;
    ls_address_i    = v.ls_addr;
    ls_writedata_i  = v.ls_wdata;
    ls_byteenable_i = v.ls_be;
    wait_issue(cyc_a);
    check($sformatf("%s owner", v.name), 32'(owner_o), 32'(v.exp_owner));
    check($sformatf("%s write", v.name), 32'(mem_write_o), 32'(v.exp_write));
    check($sformatf("%s read", v.name), 32'(mem_read_o), 32'(!v.exp_write));
    check($sformatf("%s addr", v.name), mem_address_o, v.exp_addr);
    if (v.exp_owner) begin
      check($sformatf("%s wdata", v.name), mem_writedata_o, v.ls_wdata);
      check($sformatf("%s be", v.name), 32'(mem_byteenable_o), 32'(v.ls_be));
    end
    wait_stb(cyc_b);
    check($sformatf("%s latency", v.name), 32'(cyc_a + cyc_b), 32'(v.delay + 2));
    check($sformatf("%s if_stb", v.name), 32'(if_stb_o), 32'(!v.exp_owner));
    check($sformatf("%s ls_stb", v.name), 32'(ls_stb_o), 32'(v.exp_owner));
    if (v.exp_owner) exp_ls_rd = v.rdata;
    else             exp_if_rd = v.rdata;
    check($sformatf("%s if_rdata", v.name), if_readdata_o, exp_if_rd);
    check($sformatf("%s ls_rdata", v.name), ls_readdata_o, exp_ls_rd);
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    @(negedge clk_i);
    check($sformatf("%s stb_one_cycle", v.name), 32'(if_stb_o | ls_stb_o), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          cyc;
    int          b_if, b_ls, b_ab, b_rd, b_wr;
    logic [9:0]  grant_seq;

    //           name        ifq  if_addr        lsq wr  ls_addr   ls_wdata       be     d  rdata          own wr  exp_addr
    vecs[0] = '{"fetch40",   1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0,     32'h0,         4'h0, 2, 32'h0000_0013, 1'b0, 1'b0, 32'h0000_0040};
    vecs[1] = '{"store100",  1'b0, 32'h0,         1'b1, 1'b1, 32'h0100,  32'hDEAD_BEEF, 4'hF, 2, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_0100};
    vecs[2] = '{"load204",   1'b0, 32'h0,         1'b1, 1'b0, 32'h0204,  32'h0,         4'h3, 3, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0204};
    vecs[3] = '{"both_ls",   1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0308,  32'h0,         4'hC, 2, 32'h7777_0001, 1'b1, 1'b0, 32'h0000_0308};
    vecs[4] = '{"fetch_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,     32'h0,         4'h0, 5, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vecs[5] = '{"post_rst",  1'b1, 32'h0000_0AB0, 1'b0, 1'b0, 32'h0,     32'h0,         4'h0, 2, 32'h600D_0001, 1'b0, 1'b0, 32'h0000_0AB0};

    // Asynchronous reset before any clock edge
    #1 rst_ni = 1'b0;
    #2;
    check("rst owner", 32'(owner_o), 32'd0);
    check("rst mem_addr", mem_address_o, 32'd0);
    check("rst mem_pulses", 32'({mem_read_o, mem_write_o, mem_abort_o}), 32'd0);
    check("rst stbs", 32'({if_stb_o, ls_stb_o}), 32'd0);
    check("rst if_rdata", if_readdata_o, 32'd0);
    check("rst ls_rdata", ls_readdata_o, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both requesting continuously: four load/store grants, then a forced fetch
    grant_seq       = 10'b01111_01111;
    cache_delay     = 1;
    cache_rdata     = 32'h0000_5EED;
    if_req_i        = 1'b1;
    if_address_i    = 32'h0000_0600;
    ls_req_i        = 1'b1;
    ls_write_i      = 1'b0;
    ls_address_i    = 32'h0000_0500;
    ls_byteenable_i = 4'hF;
    for (int g = 0; g < 10; g++) begin
      wait_issue(cyc);
      check($sformatf("starve grant%0d owner", g), 32'(owner_o), 32'(grant_seq[g]));
      check($sformatf("starve grant%0d addr", g), mem_address_o,
            grant_seq[g] ? 32'h0000_0500 : 32'h0000_0600);
    end
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    repeat (6) @(negedge clk_i);
    exp_if_rd = 32'h0000_5EED;
    exp_ls_rd = 32'h0000_5EED;

    // Flush while the fetch waits: one abort, the late strobe is swallowed
    b_if = n_if_stb; b_ls = n_ls_stb; b_ab = n_abort;
    cache_delay  = 4;
    cache_rdata  = 32'hBAD0_0001;
    if_req_i     = 1'b1;
    if_address_i = 32'h0000_0080;
    wait_issue(cyc);
    check("flush addr", mem_address_o, 32'h0000_0080);
    @(negedge clk_i);
    if_abort_i = 1'b1;
    if_req_i   = 1'b0;
    @(negedge clk_i);
    if_abort_i = 1'b0;
    check("flush abort_pulse", 32'(mem_abort_o), 32'd1);
    cache_delay  = 2;
    cache_rdata  = 32'h1357_9BDF;
    ls_req_i     = 1'b1;
    ls_write_i   = 1'b0;
    ls_address_i = 32'h0000_0900;
    wait_issue(cyc);
    check("flush next owner", 32'(owner_o), 32'd1);
    check("flush next addr", mem_address_o, 32'h0000_0900);
    wait_stb(cyc);
    check("flush next ls_stb", 32'(ls_stb_o), 32'd1);
    check("flush next ls_rdata", ls_readdata_o, 32'h1357_9BDF);
    check("flush if_rdata_hold", if_readdata_o, exp_if_rd);
    exp_ls_rd = 32'h1357_9BDF;
    ls_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("flush abort_count", 32'(n_abort - b_ab), 32'd1);
    check("flush if_stb_count", 32'(n_if_stb - b_if), 32'd0);
    check("flush ls_stb_count", 32'(n_ls_stb - b_ls), 32'd1);

    // Flush in the same cycle as the cache strobe: strobe wins, data dropped
    b_if = n_if_stb; b_ab = n_abort;
    cache_delay  = 3;
    cache_rdata  = 32'hDDDD_0003;
    if_req_i     = 1'b1;
    if_address_i = 32'h0000_00C0;
    wait_issue(cyc);
    repeat (3) @(negedge clk_i);
    if_abort_i = 1'b1;
    @(negedge clk_i);
    if_abort_i = 1'b0;
    if_req_i   = 1'b0;
    check("coinc no_abort", 32'(mem_abort_o), 32'd0);
    check("coinc no_if_stb", 32'(if_stb_o), 32'd0);
    cache_delay  = 2;
    cache_rdata  = 32'h0000_0A0A;
    ls_req_i     = 1'b1;
    ls_address_i = 32'h0000_0A00;
    wait_issue(cyc);
    check("coinc idle_grant_latency", 32'(cyc), 32'd1);
    wait_stb(cyc);
    check("coinc ls_rdata", ls_readdata_o, 32'h0000_0A0A);
    check("coinc if_rdata_hold", if_readdata_o, exp_if_rd);
    exp_ls_rd = 32'h0000_0A0A;
    ls_req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("coinc abort_count", 32'(n_abort - b_ab), 32'd0);
    check("coinc if_stb_count", 32'(n_if_stb - b_if), 32'd0);

    // Reset asserted mid-cycle while a load waits on the cache
    cache_delay     = 6;
    cache_rdata     = 32'hEEEE_0006;
    ls_req_i        = 1'b1;
    ls_write_i      = 1'b0;
    ls_address_i    = 32'h0000_0044;
    ls_byteenable_i = 4'hF;
    wait_issue(cyc);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("midrst owner", 32'(owner_o), 32'd0);
    check("midrst mem_addr", mem_address_o, 32'd0);
    check("midrst mem_be", 32'(mem_byteenable_o), 32'd0);
    check("midrst mem_pulses", 32'({mem_read_o, mem_write_o, mem_abort_o}), 32'd0);
    check("midrst if_rdata", if_readdata_o, 32'd0);
    check("midrst ls_rdata", ls_readdata_o, 32'd0);
    ls_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    b_if = n_if_stb; b_ls = n_ls_stb; b_rd = n_rd; b_wr = n_wr;
    rst_ni = 1'b1;
    repeat (8) @(negedge clk_i);
    check("midrst stb_count", 32'((n_if_stb - b_if) + (n_ls_stb - b_ls)), 32'd0);
    check("midrst no_reissue", 32'((n_rd - b_rd) + (n_wr - b_wr)), 32'd0);
    exp_if_rd = '0;
    exp_ls_rd = '0;
    run_vec(vecs[5]);

    check("stb one_hot", 32'(n_overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
